// File: rtl/rgb565_gray_div3_ctrl.sv
// RGB565 to 6-bit grayscale converter. Each channel is divided by 3 on one
// shared external lookup, one channel per cycle, and the three quotients are summed.
module rgb565_gray_div3_ctrl #(
    parameter bit          G_FULL = 1'b0,
    parameter int unsigned CNT_W  = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [15:0]      in_pixel,
    output logic             in_ready,
    input  logic             frame_start,
    output logic [5:0]       div_in,
    input  logic [4:0]       div_out,
    output logic             out_valid,
    output logic [5:0]       out_gray,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] pix_cnt
);

    localparam int unsigned PIX_W  = 16;
    localparam int unsigned DIN_W  = 6;
    localparam int unsigned DOUT_W = 5;
    localparam int unsigned GRAY_W = 6;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DIV_R = 3'd1,
        DIV_G = 3'd2,
        DIV_B = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [PIX_W-1:0]    pix_q, pix_d;
    logic [GRAY_W-1:0]   acc_q, acc_d;
    logic [GRAY_W-1:0]   gray_q, gray_d;
    logic                ovalid_q, ovalid_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    cnt_base;
    logic [DIN_W-1:0]    div_in_c;
    logic [GRAY_W-1:0]   quot_ext;
    logic [DIN_W-1:0]    g_operand;
    logic                done_hs;
    logic                unused_g_lsb;

    // Quotient widened to accumulator width for the running sum
    assign quot_ext  = {{(GRAY_W-DOUT_W){1'b0}}, div_out};

    // Green operand: full 6-bit G, or G>>1 so it weighs the same as R and B
    assign g_operand = G_FULL ? pix_q[10:5] : {1'b0, pix_q[10:6]};

    // G6 lsb is only consumed when the full green channel is used
    assign unused_g_lsb = pix_q[5];

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pix_q    <= '0;
            acc_q    <= '0;
            gray_q   <= '0;
            ovalid_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pix_q    <= pix_d;
            acc_q    <= acc_d;
            gray_q   <= gray_d;
            ovalid_q <= ovalid_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state, divider operand mux and accumulation
    always_comb begin
        state_d  = state_q;
        pix_d    = pix_q;
        acc_d    = acc_q;
        gray_d   = gray_q;
        ovalid_d = ovalid_q;
        div_in_c = '0;
        done_hs  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    pix_d   = in_pixel;
                    acc_d   = '0;
                    state_d = DIV_R;
                end
            end
            DIV_R: begin
                div_in_c = {1'b0, pix_q[15:11]};
                acc_d    = acc_q + quot_ext;
                state_d  = DIV_G;
            end
            DIV_G: begin
                div_in_c = g_operand;
                acc_d    = acc_q + quot_ext;
                state_d  = DIV_B;
            end
            DIV_B: begin
                div_in_c = {1'b0, pix_q[4:0]};
                gray_d   = acc_q + quot_ext;
                ovalid_d = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    ovalid_d = 1'b0;
                    done_hs  = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pixel counter: frame_start clears first, so a coincident handshake counts as 1
    assign cnt_base = frame_start ? '0 : cnt_q;
    assign cnt_d    = done_hs ? cnt_base + CNT_W'(1) : cnt_base;

    // Output mapping; in_ready is held low while reset is asserted
    assign in_ready  = rst_n & (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign div_in    = div_in_c;
    assign out_valid = ovalid_q;
    assign out_gray  = gray_q;
    assign pix_cnt   = cnt_q;

endmodule

// File: tb/tb_rgb565_gray_div3_ctrl.sv
// Bench for rgb565_gray_div3_ctrl: two instances (G_FULL=0 / 17-bit count and
// G_FULL=1 / 4-bit count) share stimulus; a scoreboard checks results in order.
module tb_rgb565_gray_div3_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_pixel;
    logic        frame_start;
    logic        out_ready;

    logic        in_ready0, out_valid0, busy0;
    logic [5:0]  div_in0, out_gray0;
    logic [4:0]  div_out0;
    logic [16:0] pix_cnt0;

    logic        in_ready1, out_valid1, busy1;
    logic [5:0]  div_in1, out_gray1;
    logic [4:0]  div_out1;
    logic [3:0]  pix_cnt1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_cnt0 = 0;
    int exp_cnt1 = 0;
    int q0[$];
    int q1[$];

    typedef struct {
        logic [15:0] pix;
        int          e0;
        int          e1;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External divide-by-3 lookups
    assign div_out0 = 5'(div_in0 / 6'd3);
    assign div_out1 = 5'(div_in1 / 6'd3);

    rgb565_gray_div3_ctrl #(.G_FULL(1'b0), .CNT_W(17)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pixel(in_pixel),
        .in_ready(in_ready0), .frame_start(frame_start), .div_in(div_in0),
        .div_out(div_out0), .out_valid(out_valid0), .out_gray(out_gray0),
        .out_ready(out_ready), .busy(busy0), .pix_cnt(pix_cnt0)
    );

    rgb565_gray_div3_ctrl #(.G_FULL(1'b1), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pixel(in_pixel),
        .in_ready(in_ready1), .frame_start(frame_start), .div_in(div_in1),
        .div_out(div_out1), .out_valid(out_valid1), .out_gray(out_gray1),
        .out_ready(out_ready), .busy(busy1), .pix_cnt(pix_cnt1)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model(input logic [15:0] p, input bit gf);
        int r, g, b;
        r = int'(p[15:11]);
        g = gf ? int'(p[10:5]) : int'(p[10:6]);
        b = int'(p[4:0]);
        return r / 3 + g / 3 + b / 3;
    endfunction

    // Scoreboard / count monitor, sampling after the falling edge
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                q0.delete();
                q1.delete();
                exp_cnt0 = 0;
                exp_cnt1 = 0;
            end else begin
                check("pix_cnt0", int'(pix_cnt0), exp_cnt0);
                check("pix_cnt1", int'(pix_cnt1), exp_cnt1);
                if (out_valid0 && out_ready) begin
                    if (q0.size() == 0) check("unexpected_out0", 1, 0);
                    else check("gray0", int'(out_gray0), q0.pop_front());
                end
                if (out_valid1 && out_ready) begin
                    if (q1.size() == 0) check("unexpected_out1", 1, 0);
                    else check("gray1", int'(out_gray1), q1.pop_front());
                end
                if (frame_start) begin
                    exp_cnt0 = 0;
                    exp_cnt1 = 0;
                end
                if (out_valid0 && out_ready) exp_cnt0 = (exp_cnt0 + 1) % (1 << 17);
                if (out_valid1 && out_ready) exp_cnt1 = (exp_cnt1 + 1) % 16;
            end
        end
    end

    // Present a pixel and wait for acceptance; returns one cycle after the accept edge
    task automatic send_pixel(input logic [15:0] pix, input int e0, input int e1);
        int t = 0;
        in_valid = 1'b1;
        in_pixel = pix;
        while (!in_ready0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("accept_timeout", 0, 1);
        q0.push_back(e0);
        q1.push_back(e1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("drain_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // Back-to-back stream with in_valid held high; accepts must be 5 cycles apart
    task automatic stream(input int n);
        int last = 0;
        int t;
        logic [15:0] p;
        in_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            p = 16'($urandom);
            in_pixel = p;
            t = 0;
            while (!in_ready0 && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (t >= 20) check("stream_timeout", 0, 1);
            if (i > 0) check("stream_period", cyc - last, 5);
            last = cyc;
            q0.push_back(model(p, 1'b0));
            q1.push_back(model(p, 1'b1));
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{pix: 16'hF800, e0: 10, e1: 10};
        vecs[1] = '{pix: 16'h07E0, e0: 10, e1: 21};
        vecs[2] = '{pix: 16'h001F, e0: 10, e1: 10};
        vecs[3] = '{pix: 16'h0000, e0: 0,  e1: 0};
        vecs[4] = '{pix: 16'h8410, e0: 15, e1: 20};
        vecs[5] = '{pix: 16'hFFFF, e0: 30, e1: 41};

        rst_n = 1'b0; in_valid = 1'b0; in_pixel = '0;
        frame_start = 1'b0; out_ready = 1'b0;

        // Reset state
        #2;
        check("rst_out_valid", int'(out_valid0), 0);
        check("rst_out_gray", int'(out_gray0), 0);
        check("rst_in_ready", int'(in_ready0), 0);
        check("rst_busy", int'(busy0), 0);
        check("rst_div_in", int'(div_in0), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", int'(in_ready0), 1);

        // Operand sequence and latency for 0xFFFF
        send_pixel(16'hFFFF, 30, 41);
        check("divr_in0", int'(div_in0), 31);
        check("divr_in1", int'(div_in1), 31);
        check("divr_busy", int'(busy0), 1);
        check("divr_in_ready", int'(in_ready0), 0);
        @(negedge clk);
        check("divg_in0", int'(div_in0), 31);
        check("divg_in1", int'(div_in1), 63);
        @(negedge clk);
        check("divb_in0", int'(div_in0), 31);
        check("divb_out_valid", int'(out_valid0), 0);
        @(negedge clk);
        check("done_out_valid", int'(out_valid0), 1);
        check("done_gray0", int'(out_gray0), 30);
        check("done_gray1", int'(out_gray1), 41);
        check("done_div_in", int'(div_in0), 0);

        // Backpressure in DONE with in_valid pulses that must be ignored
        for (int i = 0; i < 6; i++) begin
            in_valid = (i % 2) == 0;
            in_pixel = 16'h1234;
            check("bp_out_valid", int'(out_valid0), 1);
            check("bp_gray", int'(out_gray0), 30);
            check("bp_in_ready", int'(in_ready0), 0);
            check("bp_pix_cnt", int'(pix_cnt0), 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("hs_out_valid", int'(out_valid0), 0);
        check("hs_pix_cnt", int'(pix_cnt0), 1);

        // Vector table
        for (int i = 0; i < 6; i++) begin
            send_pixel(vecs[i].pix, vecs[i].e0, vecs[i].e1);
            wait_drain();
        end
        check("table_pix_cnt", int'(pix_cnt0), 7);

        // frame_start alone
        pulse_frame_start();
        check("fs_pix_cnt0", int'(pix_cnt0), 0);
        check("fs_pix_cnt1", int'(pix_cnt1), 0);

        // frame_start coincident with the DONE handshake
        send_pixel(16'h001F, 10, 10);
        wait_drain();
        check("pre_fs_cnt", int'(pix_cnt0), 1);
        out_ready = 1'b0;
        send_pixel(16'h8410, 15, 20);
        begin
            int t = 0;
            while (!out_valid0 && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (t >= 20) check("out_valid_timeout", 0, 1);
        end
        out_ready = 1'b1;
        pulse_frame_start();
        check("fs_hs_cnt0", int'(pix_cnt0), 1);
        check("fs_hs_cnt1", int'(pix_cnt1), 1);

        // Streaming, then counter wrap on the 4-bit instance
        pulse_frame_start();
        stream(8);
        check("stream_cnt0", int'(pix_cnt0), 8);
        stream(8);
        check("wrap_cnt0", int'(pix_cnt0), 16);
        check("wrap_cnt1", int'(pix_cnt1), 0);

        // Asynchronous reset during DIV_G
        send_pixel(16'hFFFF, 30, 41);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", int'(out_valid0), 0);
        check("arst_out_gray", int'(out_gray0), 0);
        check("arst_pix_cnt", int'(pix_cnt0), 0);
        check("arst_busy", int'(busy0), 0);
        check("arst_in_ready", int'(in_ready0), 0);
        check("arst_div_in", int'(div_in0), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", int'(in_ready0), 1);
        check("post_rst_out_valid", int'(out_valid0), 0);
        check("post_rst_pix_cnt", int'(pix_cnt0), 0);
        send_pixel(16'hFFFF, 30, 41);
        wait_drain();
        check("post_rst_final_cnt", int'(pix_cnt0), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
